// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maze_pkg
//  Brief    : Shared constants and encodings for the maze store and solver.
//  Revision : 1.0  initial release
// ============================================================================
package maze_pkg;

    // Default coordinate width; grid side is 2**c_MAZE_WIDTH.
    localparam int c_MAZE_WIDTH = 6;
    // Default width of the path counter.
    localparam int c_CNT_W      = 13;

    // Solver move directions.
    localparam logic [1:0] c_RIGHT = 2'd0;
    localparam logic [1:0] c_DOWN  = 2'd1;
    localparam logic [1:0] c_LEFT  = 2'd2;
    localparam logic [1:0] c_UP    = 2'd3;

    // Cell encoding as seen by a solver.
    typedef enum logic [1:0] {
        CELL_FREE = 2'd0,
        CELL_WALL = 2'd1,
        CELL_PATH = 2'd2
    } cell_e;

    // Store controller states.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DUMP  = 2'd2
    } store_state_e;

endpackage : maze_pkg
`default_nettype wire

// File: rtl/maze_bitmap.sv
`default_nettype none
// ============================================================================
//  Module   : maze_bitmap
//  Brief    : N x N bit array, one row-write port, one bit-set port,
//             one bit-read port and one row-read port (reads combinational).
//  Revision : 1.0  initial release
// ============================================================================
module maze_bitmap #(
    parameter  int W = 6,
    localparam int N = 2**W
) (
    input  logic         clk,
    input  logic         i_row_we,
    input  logic [W-1:0] i_row_waddr,
    input  logic [N-1:0] i_row_wdata,
    input  logic         i_set_en,
    input  logic [W-1:0] i_set_row,
    input  logic [W-1:0] i_set_col,
    input  logic [W-1:0] i_rd_row,
    input  logic [W-1:0] i_rd_col,
    output logic         o_rd_bit,
    input  logic [W-1:0] i_rrow_addr,
    output logic [N-1:0] o_rrow_data
);

    logic [N-1:0] r_mem [N];

    // Row write takes priority over a bit set aimed at the same row.
    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            if (i_row_we && (i_row_waddr == W'(r))) begin
                r_mem[r] <= i_row_wdata;
            end else if (i_set_en && (i_set_row == W'(r))) begin
                r_mem[r][i_set_col] <= 1'b1;
            end
        end
    end

    assign o_rd_bit    = r_mem[i_rd_row][i_rd_col];
    assign o_rrow_data = r_mem[i_rrow_addr];

endmodule : maze_bitmap
`default_nettype wire

// File: rtl/maze_store.sv
`default_nettype none
// ============================================================================
//  Module   : maze_store
//  Brief    : Memory-side responder for the maze solver. Loads a wall grid,
//             serves reads / path marks, then dumps the path map row by row.
//  Revision : 1.0  initial release
// ============================================================================
module maze_store
    import maze_pkg::*;
#(
    parameter  int MAZE_WIDTH = c_MAZE_WIDTH,
    parameter  int CNT_W      = c_CNT_W,
    localparam int N          = 2**MAZE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [N-1:0]          i_load_data,
    input  logic [MAZE_WIDTH-1:0] i_row,
    input  logic [MAZE_WIDTH-1:0] i_col,
    input  logic                  i_maze_oe,
    input  logic                  i_maze_we,
    output logic                  o_maze_in,
    output logic                  o_maze_ready,
    input  logic                  i_dump_req,
    output logic                  o_dump_valid,
    output logic [MAZE_WIDTH-1:0] o_dump_row,
    output logic [N-1:0]          o_dump_data,
    output logic [CNT_W-1:0]      o_path_count,
    output logic                  o_err_wall,
    output logic                  o_err_idle
);

    store_state_e          r_state;
    store_state_e          w_next;
    logic [MAZE_WIDTH-1:0] r_load_cnt;
    logic                  r_load_ready;
    logic                  r_maze_ready;
    logic                  r_maze_in;
    logic                  r_dump_valid;
    logic [MAZE_WIDTH-1:0] r_dump_row;
    logic [N-1:0]          r_dump_data;
    logic [CNT_W-1:0]      r_path_count;
    logic                  r_err_wall;
    logic                  r_err_idle;

    logic                  w_load_fire;
    logic                  w_serve;
    logic                  w_wall_bit;
    logic                  w_path_bit;
    logic                  w_path_set;
    logic                  w_cnt_inc;
    logic [MAZE_WIDTH-1:0] w_dump_addr;
    logic [N-1:0]          w_path_row;
    logic [N-1:0]          w_wall_row;

    assign w_load_fire = (r_state == ST_LOAD) && r_load_ready && i_load_valid;
    assign w_serve     = (r_state == ST_SERVE);
    // A mark lands only on a non-wall cell; it counts only if new.
    assign w_path_set  = w_serve && i_maze_we && !w_wall_bit;
    assign w_cnt_inc   = w_path_set && !w_path_bit;
    // Row fetched for the beat being registered at this edge.
    assign w_dump_addr = (r_state == ST_DUMP) ? (r_dump_row + 1'b1) : '0;

    maze_bitmap #(.W(MAZE_WIDTH)) u_walls (
        .clk         (clk),
        .i_row_we    (w_load_fire),
        .i_row_waddr (r_load_cnt),
        .i_row_wdata (i_load_data),
        .i_set_en    (1'b0),
        .i_set_row   ('0),
        .i_set_col   ('0),
        .i_rd_row    (i_row),
        .i_rd_col    (i_col),
        .o_rd_bit    (w_wall_bit),
        .i_rrow_addr ('0),
        .o_rrow_data (w_wall_row)
    );

    maze_bitmap #(.W(MAZE_WIDTH)) u_path (
        .clk         (clk),
        .i_row_we    (w_load_fire),
        .i_row_waddr (r_load_cnt),
        .i_row_wdata ('0),
        .i_set_en    (w_path_set),
        .i_set_row   (i_row),
        .i_set_col   (i_col),
        .i_rd_row    (i_row),
        .i_rd_col    (i_col),
        .o_rd_bit    (w_path_bit),
        .i_rrow_addr (w_dump_addr),
        .o_rrow_data (w_path_row)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: last load beat, dump request, last dump beat.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD:  if (w_load_fire && (r_load_cnt == MAZE_WIDTH'(N-1))) w_next = ST_SERVE;
            ST_SERVE: if (i_dump_req) w_next = ST_DUMP;
            ST_DUMP:  if (r_dump_row == MAZE_WIDTH'(N-1)) w_next = ST_LOAD;
            default:  w_next = ST_LOAD;
        endcase
    end

    // Datapath: load counter, read data, dump beats, statistics and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_cnt   <= '0;
            r_load_ready <= 1'b0;
            r_maze_ready <= 1'b0;
            r_maze_in    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_row   <= '0;
            r_dump_data  <= '0;
            r_path_count <= '0;
            r_err_wall   <= 1'b0;
            r_err_idle   <= 1'b0;
        end else begin
            r_load_ready <= (w_next == ST_LOAD);
            r_maze_ready <= (w_next == ST_SERVE);

            if (w_load_fire) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end

            if (w_serve && i_maze_oe) begin
                r_maze_in <= w_wall_bit;
            end
            if (w_cnt_inc && (r_path_count != '1)) begin
                r_path_count <= r_path_count + 1'b1;
            end
            if (w_serve && i_maze_we && w_wall_bit) begin
                r_err_wall <= 1'b1;
            end
            if (!w_serve && (i_maze_oe || i_maze_we)) begin
                r_err_idle <= 1'b1;
            end

            if (w_serve && i_dump_req) begin
                r_dump_valid <= 1'b1;
                r_dump_row   <= '0;
                r_dump_data  <= w_path_row;
            end else if (r_state == ST_DUMP) begin
                if (r_dump_row == MAZE_WIDTH'(N-1)) begin
                    // Back to LOAD: start a fresh set of statistics.
                    r_dump_valid <= 1'b0;
                    r_path_count <= '0;
                    r_err_wall   <= 1'b0;
                    r_err_idle   <= 1'b0;
                end else begin
                    r_dump_row  <= r_dump_row + 1'b1;
                    r_dump_data <= w_path_row;
                end
            end
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_maze_ready = r_maze_ready;
    assign o_maze_in    = r_maze_in;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_row   = r_dump_row;
    assign o_dump_data  = r_dump_data;
    assign o_path_count = r_path_count;
    assign o_err_wall   = r_err_wall;
    assign o_err_idle   = r_err_idle;

endmodule : maze_store
`default_nettype wire

// File: doc/maze_store.md
Name: maze_store

Overview:
- Memory-side responder for the maze solver's cell interface: `row`/`col`/`maze_oe`/`maze_we` in, `maze_in` out.
- Holds a 2^maze_width × 2^maze_width grid with per-cell wall and path bits.
- The grid is loaded row-by-row by a testbench or host before solving. Read reports the wall bit; write marks the cell as path.
- After the solve, the path map can be dumped row-by-row, and write statistics and error flags are kept.

Parameters:
- maze_width, 6, coordinate width; grid side N = 2^maze_width (64).
- CNT_W, 13, width of path_count; saturates at all-ones.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- load_valid  in  1  load beat valid.
- load_ready  out  1  high in LOAD state.
- load_data  in  N  wall bits of the current load row; bit c = column c; 1 = wall.
- row  in  maze_width  solver row address.
- col  in  maze_width  solver column address.
- maze_oe  in  1  read strobe.
- maze_we  in  1  mark-path strobe.
- maze_in  out  1  wall bit of the last cell read.
- maze_ready  out  1  high in SERVE state.
- dump_req  in  1  single-cycle request to dump the path map.
- dump_valid  out  1  dump row valid.
- dump_row  out  maze_width  index of the row being dumped.
- dump_data  out  N  path bits of that row.
- path_count  out  CNT_W  number of distinct cells newly marked.
- err_wall  out  1  sticky: write to a wall cell.
- err_idle  out  1  sticky: oe or we outside SERVE.

Behaviour:
- Reset:
  - State goes to LOAD; load row counter = 0.
  - Outputs cleared: maze_in, maze_ready, dump_valid, dump_row, dump_data, path_count, err_wall, err_idle.
  - load_ready = 1 in the cycle after reset deasserts.
  - Array contents are not reset.
- State LOAD:
  - Each cycle with load_valid & load_ready: walls[cnt] <= load_data, path[cnt] <= 0, cnt++.
  - The beat with cnt = N-1 transitions to SERVE; cnt wraps to 0.
  - Entry to LOAD (via reset or reload) also clears path_count, err_wall and err_idle.
- State SERVE (maze_ready = 1):
  - Read, fixed 1-cycle latency: when maze_oe is high at edge k, maze_in = walls[row][col] from edge k+1.
  - maze_in holds its value until the next accepted oe.
  - Write: when maze_we is high, the cell is marked only if its wall bit = 0:
    - If path[row][col] = 0: set it and increment path_count, saturating.
    - If already 1: no count change.
  - Write to a wall cell: cell not marked, err_wall <= 1.
  - oe and we together: both performed; the read returns the wall bit, which a write never changes.
  - dump_req high: enter DUMP. oe/we in that same cycle are still served.
- State DUMP:
  - For exactly N consecutive cycles, drive dump_valid = 1, dump_row = i, dump_data = path[i], for i = 0..N-1.
  - Registered output: the first beat appears one cycle after dump_req is accepted.
  - After beat N-1: dump_valid = 0 and return to LOAD, allowing a new maze.
  - dump_req while already in DUMP: ignored.
- oe/we in LOAD or DUMP: ignored (maze_in unchanged, no write), err_idle <= 1.
- load_valid outside LOAD: ignored, no error.
- Reset mid-LOAD or mid-DUMP: abandon the operation and return to LOAD, row 0. Partially loaded rows remain in the array but are overwritten by the next load.
- Address arithmetic: row/col are used directly as indices; the full range 0..N-1 is valid, with no wrap handling needed.

Decomposition:
- Shared package `maze_pkg`:
  - Default maze_width.
  - Direction constants RIGHT=0, DOWN=1, LEFT=2, UP=3.
  - Cell encoding: FREE=0, WALL=1, PATH=2.
  - store state encoding: LOAD, SERVE, DUMP.
- One natural sub-module `maze_bitmap`: an N×N bit array with one row-write port, one bit-set port, one bit-read port and one row-read port. It is instantiated twice, once for walls and once for path.
- The FSM, counters and flags stay in the top level.

Test Plan:
- Load 64 rows, all 0 except row 5 = 64'h0000_0000_0000_0010 (cell 5,4 = wall); load_ready drops after beat 64. Then oe at (5,4) -> maze_in = 1 next cycle; oe at (5,3) -> maze_in = 0.
- SERVE, three writes at (10,10), (10,11), (10,10) -> path_count = 2, err_wall = 0.
- Write at wall cell (5,4) -> err_wall = 1, path_count unchanged, cell not marked in the dump.
- After the writes above, pulse dump_req -> 64 beats, dump_row 0..63; row 10 dump_data = bits 10 and 11 set, all other rows 0; then load_ready = 1 and path_count = 0.
- oe during LOAD (before beat 64) -> err_idle = 1 and maze_in unchanged; reset (rst_n = 0 for one cycle) mid-dump at beat 20 -> dump_valid = 0 and load_ready = 1 in the cycle after rst_n returns high, err_idle = 0.
- Connect the maze solver with start (1,1) on a 64×64 maze whose single exit is (0,7) -> solver done = 1; exit cell marked; err_wall = 0; err_idle = 0.
